// File: rtl/jtag_host_shifter.sv
// -----------------------------------------------------------------------------
// jtag_host_shifter
//
// Host-side JTAG sequencer. It accepts high-level commands (TAP reset, IR scan,
// DR scan, idle clocks) and turns them into TMS/TDI bit streams. TDO bits seen
// while the target is in SHIFT_DR/SHIFT_IR are collected into a response word.
// The host keeps a mirror of the target TAP state, advanced on every posedge
// from the TMS value it presented.
//
// Optional build macro: JTAG_HOST_RTI_PAD_EN
//   When defined, every IR/DR scan ends with two extra TMS=0 edges in
//   RUN_TEST_IDLE before the response. This gives the target time to act on an
//   UPDATE side effect.
//
// Ports
//   tck        TAP clock. State changes on posedge; TMS/TDI change on negedge.
//   trstn      asynchronous active-low reset
//   cmd_valid  command request (must be held until accepted)
//   cmd_ready  idle in RUN_TEST_IDLE and able to accept a command
//   cmd_op     0=TAP_RESET 1=IR_SCAN 2=DR_SCAN 3=IDLE_CLKS
//   cmd_len    scan length in bits, or idle-cycle count
//   cmd_wdata  TDI data, LSB shifted first
//   rsp_valid  one-cycle completion pulse
//   rsp_err    illegal scan length (qualified by rsp_valid)
//   rsp_rdata  captured TDO bits, LSB = first sample; held between responses
//   tdo        TDO from the target
//   tms, tdi   to the target
//   tap_state  mirrored target TAP state
// -----------------------------------------------------------------------------
package jtag_host_shifter_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_ctrl_fsm_t;

  localparam logic [1:0] OP_TAP_RESET = 2'd0;
  localparam logic [1:0] OP_IR_SCAN   = 2'd1;
  localparam logic [1:0] OP_DR_SCAN   = 2'd2;
  localparam logic [1:0] OP_IDLE_CLKS = 2'd3;
endpackage

module jtag_host_shifter
  import jtag_host_shifter_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               trstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_rdata,
  input  logic               tdo,
  output logic               tms,
  output logic               tdi,
  output tap_ctrl_fsm_t      tap_state
);

  // One extra bit over LEN_W so a maximal scan plus its framing edges fits.
  localparam int CNT_W = LEN_W + 1;
`ifdef JTAG_HOST_RTI_PAD_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif

  typedef enum logic [1:0] {SQ_INIT, SQ_IDLE, SQ_BUSY} seq_t;

  seq_t               seq_q, seq_d;
  logic [1:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, total_q, total_d, cmd_total;
  logic [MAX_LEN-1:0] tx_q, tx_d, rx_q, rx_d, mask_q, mask_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [MAX_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
  tap_ctrl_fsm_t      tap_q;
  logic               tms_q, tdi_q, tms_d, tdi_d;
  logic               is_scan, len_bad, shifting;

  // Standard 16-state TAP transition.
  function automatic tap_ctrl_fsm_t tap_next(input tap_ctrl_fsm_t s, input logic m);
    tap_ctrl_fsm_t n;
    case (s)
      TEST_LOGIC_RESET: n = m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = m ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       n = m ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = m ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = m ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = m ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = m ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = m ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = m ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = m ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = m ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = m ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

  // TMS for edge index e of a command. Scans: preamble (DR 1,0,0 / IR 1,1,0,0),
  // len shift edges with TMS=1 on the last, then 1 (UPDATE), then 0s (RTI/pad).
  function automatic logic seq_tms(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                   input logic [CNT_W-1:0] e);
    logic [CNT_W-1:0] pre, shend;
    logic             b;
    pre   = (op == OP_IR_SCAN) ? CNT_W'(4) : CNT_W'(3);
    shend = pre + CNT_W'(len);
    case (op)
      OP_TAP_RESET: b = (e < CNT_W'(5));
      OP_IDLE_CLKS: b = 1'b0;
      default: begin
        if (e < pre)        b = (op == OP_IR_SCAN) ? (e < CNT_W'(2)) : (e == '0);
        else if (e < shend) b = (e == shend - CNT_W'(1));
        else                b = (e == shend);
      end
    endcase
    return b;
  endfunction

  assign is_scan  = (cmd_op == OP_IR_SCAN) || (cmd_op == OP_DR_SCAN);
  assign len_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
  // The mirror holds the state before the coming edge, so this marks shift edges.
  assign shifting = (tap_q == SHIFT_DR) || (tap_q == SHIFT_IR);

  always_comb begin
    case (cmd_op)
      OP_TAP_RESET: cmd_total = CNT_W'(6);
      OP_IR_SCAN:   cmd_total = CNT_W'(cmd_len) + CNT_W'(6 + PAD);
      OP_DR_SCAN:   cmd_total = CNT_W'(cmd_len) + CNT_W'(5 + PAD);
      default:      cmd_total = CNT_W'(cmd_len);
    endcase
  end

  always_comb begin
    seq_d       = seq_q;
    op_d        = op_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    mask_d      = mask_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    case (seq_q)
      SQ_INIT: begin
        // TMS=0 walks the mirror out of TEST_LOGIC_RESET; ready the cycle after.
        if (tap_q == RUN_TEST_IDLE) seq_d = SQ_IDLE;
      end
      SQ_IDLE: begin
        if (cmd_valid) begin
          if (is_scan && len_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (cmd_total == '0) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            seq_d   = SQ_BUSY;
            op_d    = cmd_op;
            len_d   = cmd_len;
            cnt_d   = '0;
            total_d = cmd_total;
            tx_d    = cmd_wdata;
            rx_d    = '0;
            mask_d  = MAX_LEN'(1);
          end
        end
      end
      SQ_BUSY: begin
        tms_d = seq_tms(op_q, len_q, cnt_q);
        if (shifting) begin
          tdi_d  = tx_q[0];
          tx_d   = tx_q >> 1;
          mask_d = mask_q << 1;
          if (tdo) rx_d = rx_q | mask_q;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == total_q - CNT_W'(1)) begin
          seq_d       = SQ_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_d;
        end
      end
      default: seq_d = SQ_INIT;
    endcase
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      seq_q       <= SQ_INIT;
      op_q        <= OP_TAP_RESET;
      len_q       <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      tap_q       <= TEST_LOGIC_RESET;
    end else begin
      seq_q       <= seq_d;
      op_q        <= op_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      tap_q       <= tap_next(tap_q, tms_q);
    end
  end

  // Negedge presentation: the target samples each bit on the following posedge.
  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else begin
      tms_q <= tms_d;
      tdi_q <= tdi_d;
    end
  end

  assign cmd_ready = (seq_q == SQ_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign tap_state = tap_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
module tb_jtag_host_shifter;
  import jtag_host_shifter_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef JTAG_HOST_RTI_PAD_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif
  localparam logic [3:0]  IR_IDCODE  = 4'h1;
  localparam logic [3:0]  IR_BYPASS  = 4'hF;
  localparam logic [31:0] IDCODE_VAL = 32'h0000_010F;

  logic               tck = 1'b0;
  logic               trstn = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_wdata = '0;
  logic               rsp_valid, rsp_err;
  logic [MAX_LEN-1:0] rsp_rdata;
  logic               tdo, tms, tdi;
  tap_ctrl_fsm_t      tap_state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          edges;
  } exp_t;
  exp_t sb[$];

  jtag_host_shifter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck(tck), .trstn(trstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .tdo(tdo), .tms(tms), .tdi(tdi), .tap_state(tap_state)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- target TAP model (4-bit IR, IDCODE / BYPASS) -------------
  function automatic tap_ctrl_fsm_t tgt_step(input tap_ctrl_fsm_t s, input logic m);
    case (s)
      TEST_LOGIC_RESET: return m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return m ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       return m ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         return m ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         return m ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         return m ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         return m ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        return m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   return m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return m ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         return m ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         return m ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         return m ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         return m ? UPDATE_IR        : SHIFT_IR;
      default:          return m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
    endcase
  endfunction

  tap_ctrl_fsm_t t_state;
  logic [3:0]    t_ir, t_ir_sr;
  logic [31:0]   t_dr_sr;
  logic          t_byp, t_tdo;

  always @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      t_state <= TEST_LOGIC_RESET;
      t_ir    <= IR_IDCODE;
      t_ir_sr <= 4'h0;
      t_dr_sr <= 32'h0;
      t_byp   <= 1'b0;
    end else begin
      case (t_state)
        TEST_LOGIC_RESET: t_ir <= IR_IDCODE;
        CAPTURE_IR:       t_ir_sr <= 4'b0001;
        SHIFT_IR:         t_ir_sr <= {tdi, t_ir_sr[3:1]};
        UPDATE_IR:        t_ir <= t_ir_sr;
        CAPTURE_DR: begin
          t_dr_sr <= (t_ir == IR_IDCODE) ? IDCODE_VAL : 32'h0;
          t_byp   <= 1'b0;
        end
        SHIFT_DR: begin
          t_dr_sr <= {tdi, t_dr_sr[31:1]};
          t_byp   <= tdi;
        end
        default: ;
      endcase
      t_state <= tgt_step(t_state, tms);
    end
  end

  always @(negedge tck or negedge trstn) begin
    if (!trstn) t_tdo <= 1'b0;
    else if (t_state == SHIFT_IR) t_tdo <= t_ir_sr[0];
    else if (t_state == SHIFT_DR) t_tdo <= (t_ir == IR_IDCODE) ? t_dr_sr[0] : t_byp;
    else t_tdo <= 1'b0;
  end
  assign tdo = t_tdo;

  // ---------------- checking helpers ----------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge tck); #1;
    while (!cmd_ready && n < 60) begin
      @(negedge tck); #1;
      n++;
    end
    check("ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input int len,
                         input logic [63:0] wd, input logic [63:0] exp_rd,
                         input logic exp_err, input int exp_edges,
                         output logic [127:0] trace, output logic saw_tlr);
    exp_t e, g;
    int   edges;
    logic got;
    e.rd = exp_rd; e.err = exp_err; e.edges = exp_edges;
    sb.push_back(e);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LEN_W'(len); cmd_wdata = wd;
    @(posedge tck); #1;
    cmd_valid = 1'b0; cmd_len = '0; cmd_wdata = '0;
    edges = 0; got = 1'b0; trace = '0; saw_tlr = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge tck); #1;
      if (rsp_valid) got = 1'b1;
      else begin
        if (k == 0) check({name, "_ready_low"}, cmd_ready, 1'b0);
        check({name, "_mirror"}, tap_state, t_state);
        if (tap_state == TEST_LOGIC_RESET) saw_tlr = 1'b1;
        if (edges < 128) trace[edges] = tms;
        edges++;
      end
    end
    check({name, "_rsp_seen"}, got, 1'b1);
    check({name, "_sb_depth"}, sb.size(), 1);
    g = sb.pop_front();
    if (got) begin
      check({name, "_rdata"}, rsp_rdata, g.rd);
      check({name, "_err"}, rsp_err, g.err);
      check({name, "_edges"}, edges, g.edges);
      check({name, "_end_rti"}, tap_state, RUN_TEST_IDLE);
      check({name, "_ready_at_rsp"}, cmd_ready, 1'b1);
      if (g.edges == 0) check({name, "_tms_quiet"}, tms, 1'b0);
      @(negedge tck); #1;
      check({name, "_rsp_pulse"}, rsp_valid, 1'b0);
    end
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    logic [127:0] tr;
    logic         stl;
    int           stray;
    trstn = 1'b0;
    repeat (2) @(negedge tck);
    #1;
    check("rst_tms", tms, 1'b1);
    check("rst_tdi", tdi, 1'b0);
    check("rst_state", tap_state, TEST_LOGIC_RESET);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rdata", rsp_rdata, 64'h0);

    @(posedge tck); #1 trstn = 1'b1;
    @(negedge tck); #1 check("init_tms0", tms, 1'b0);
    @(posedge tck); #1;
    check("init_rti", tap_state, RUN_TEST_IDLE);
    check("init_ready_low", cmd_ready, 1'b0);
    @(posedge tck); #1 check("init_ready", cmd_ready, 1'b1);

    run_cmd("ir_idcode", OP_IR_SCAN, 4, {60'h0, IR_IDCODE}, 64'h1, 1'b0, 10 + PAD, tr, stl);
    run_cmd("dr_idcode", OP_DR_SCAN, 32, 64'h0, 64'h0000_010F, 1'b0, 37 + PAD, tr, stl);
    run_cmd("ir_bypass", OP_IR_SCAN, 4, {60'h0, IR_BYPASS}, 64'h1, 1'b0, 10 + PAD, tr, stl);
    run_cmd("dr_bypass", OP_DR_SCAN, 8, 64'hA5, 64'h4A, 1'b0, 13 + PAD, tr, stl);
    run_cmd("dr_len0", OP_DR_SCAN, 0, 64'hFF, 64'h4A, 1'b1, 0, tr, stl);
    run_cmd("dr_len65", OP_DR_SCAN, 65, 64'hFF, 64'h4A, 1'b1, 0, tr, stl);

    run_cmd("tap_reset", OP_TAP_RESET, 0, 64'h0, 64'h0, 1'b0, 6, tr, stl);
    check("tap_reset_tms_seq", tr[5:0], 6'b011111);
    check("tap_reset_saw_tlr", stl, 1'b1);

    run_cmd("idle3", OP_IDLE_CLKS, 3, 64'h0, 64'h0, 1'b0, 3, tr, stl);
    check("idle3_tms_seq", tr[2:0], 3'b000);
    run_cmd("idle0", OP_IDLE_CLKS, 0, 64'h0, 64'h0, 1'b0, 0, tr, stl);

    // Full-width scan: IDCODE then the first 32 written bits delayed by 32.
    run_cmd("dr_max", OP_DR_SCAN, 64, 64'hDEADBEEF_12345678,
            64'h12345678_0000010F, 1'b0, 69 + PAD, tr, stl);

    // Abort a len=32 DR scan during shift bit 10.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_DR_SCAN; cmd_len = LEN_W'(32); cmd_wdata = '0;
    @(posedge tck); #1 cmd_valid = 1'b0;
    repeat (14) @(negedge tck);
    #1;
    check("abort_in_shift", tap_state, SHIFT_DR);
    trstn = 1'b0;
    #1;
    check("abort_tms", tms, 1'b1);
    check("abort_tdi", tdi, 1'b0);
    check("abort_state", tap_state, TEST_LOGIC_RESET);
    check("abort_ready", cmd_ready, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rdata", rsp_rdata, 64'h0);
    stray = 0;
    repeat (3) begin
      @(negedge tck); #1;
      if (rsp_valid) stray++;
    end
    @(posedge tck); #1 trstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge tck); #1;
      if (rsp_valid) stray++;
    end
    check("abort_no_rsp", stray, 0);
    run_cmd("dr_after_abort", OP_DR_SCAN, 32, 64'h0, 64'h0000_010F, 1'b0, 37 + PAD, tr, stl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
